// File: rtl/recepcao_serial_bcd.sv
// Serial 7O1 receiver feeding a packet assembler that turns "ddd#" into a
// 3-digit BCD measurement, with one-cycle pronto/erro pulses per packet.
module recepcao_serial_bcd #(
  parameter int CICLOS_BIT = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        entrada_serial,
  output logic [11:0] dados,
  output logic        pronto,
  output logic        erro,
  output logic [3:0]  db_estado
);

  localparam int CNT_W = $clog2(CICLOS_BIT);
  localparam logic [CNT_W-1:0] FIM_BIT  = CNT_W'(CICLOS_BIT - 1);
  localparam logic [CNT_W-1:0] FIM_MEIO = CNT_W'(CICLOS_BIT / 2 - 1);

  typedef enum logic [2:0] {
    OCIOSO,
    INICIO,
    DADOS,
    PARIDADE,
    PARADA
  } estado_bit_t;

  typedef enum logic [1:0] {
    ESPERA_D2   = 2'd0,
    ESPERA_D1   = 2'd1,
    ESPERA_D0   = 2'd2,
    ESPERA_HASH = 2'd3
  } estado_pac_t;

  logic sinc_0, sinc_1;

  // Synchronizer resets to the idle level so reset itself never looks like a start bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sinc_0 <= 1'b1;
      sinc_1 <= 1'b1;
    end else begin
      // NOTE: non-blocking so each flop samples its input at the same edge;
      // blocking here would collapse the chain into a single flop.
      sinc_0 <= entrada_serial;
      sinc_1 <= sinc_0;
    end
  end

  estado_bit_t      estado_bit;
  logic [CNT_W-1:0] contador;
  logic [2:0]       indice;
  logic [6:0]       deslocamento;
  logic             erro_paridade;
  logic             espera_linha;
  logic             car_valido;
  logic             car_erro;
  logic [6:0]       car_dado;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_bit    <= OCIOSO;
      contador      <= '0;
      indice        <= '0;
      deslocamento  <= '0;
      erro_paridade <= 1'b0;
      espera_linha  <= 1'b0;
      car_valido    <= 1'b0;
      car_erro      <= 1'b0;
      car_dado      <= '0;
    end else begin
      car_valido <= 1'b0;
      case (estado_bit)
        OCIOSO: begin
          contador <= '0;
          if (!sinc_1) estado_bit <= INICIO;
        end
        INICIO: begin
          if (contador == FIM_MEIO) begin
            contador <= '0;
            indice   <= '0;
            estado_bit <= sinc_1 ? OCIOSO : DADOS;
          end else begin
            contador <= contador + 1'b1;
          end
        end
        DADOS: begin
          if (contador == FIM_BIT) begin
            contador     <= '0;
            deslocamento <= {sinc_1, deslocamento[6:1]};
            indice       <= indice + 3'd1;
            if (indice == 3'd6) estado_bit <= PARIDADE;
          end else begin
            contador <= contador + 1'b1;
          end
        end
        PARIDADE: begin
          if (contador == FIM_BIT) begin
            contador      <= '0;
            erro_paridade <= ~(^{deslocamento, sinc_1});
            estado_bit    <= PARADA;
          end else begin
            contador <= contador + 1'b1;
          end
        end
        PARADA: begin
          // After a framing error the line must return high before a new start is trusted.
          if (espera_linha) begin
            if (sinc_1) begin
              espera_linha <= 1'b0;
              estado_bit   <= OCIOSO;
            end
          end else if (contador == FIM_BIT) begin
            contador   <= '0;
            car_valido <= 1'b1;
            car_dado   <= deslocamento;
            car_erro   <= erro_paridade | ~sinc_1;
            if (sinc_1) estado_bit <= OCIOSO;
            else        espera_linha <= 1'b1;
          end else begin
            contador <= contador + 1'b1;
          end
        end
        default: estado_bit <= OCIOSO;
      endcase
    end
  end

  estado_pac_t estado_pac;
  logic [11:0] parcial;
  logic        eh_digito;
  logic        eh_hash;

  assign eh_digito = (car_dado[6:4] == 3'b011) && (car_dado[3:0] <= 4'd9);
  assign eh_hash   = (car_dado == 7'h23);
  assign db_estado = {2'b00, estado_pac};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_pac <= ESPERA_D2;
      parcial    <= '0;
      dados      <= '0;
      pronto     <= 1'b0;
      erro       <= 1'b0;
    end else begin
      pronto <= 1'b0;
      erro   <= 1'b0;
      if (car_valido) begin
        if (!car_erro && eh_digito && estado_pac != ESPERA_HASH) begin
          case (estado_pac)
            ESPERA_D2: begin
              parcial[11:8] <= car_dado[3:0];
              estado_pac    <= ESPERA_D1;
            end
            ESPERA_D1: begin
              parcial[7:4] <= car_dado[3:0];
              estado_pac   <= ESPERA_D0;
            end
            default: begin
              parcial[3:0] <= car_dado[3:0];
              estado_pac   <= ESPERA_HASH;
            end
          endcase
        end else if (!car_erro && eh_hash && estado_pac == ESPERA_HASH) begin
          dados      <= parcial;
          pronto     <= 1'b1;
          estado_pac <= ESPERA_D2;
        end else begin
          // '#' out of place doubles as the resync marker: drop the packet and restart.
          erro       <= 1'b1;
          estado_pac <= ESPERA_D2;
        end
      end
    end
  end

endmodule

// File: tb/tb_recepcao_serial_bcd.sv
// Bench for recepcao_serial_bcd: directed packet scenarios plus random packets,
// checked against a digit-queue model of the packet rules.
module tb_recepcao_serial_bcd;

  localparam int C    = 16;
  localparam int HALF = C / 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        entrada_serial;
  logic [11:0] dados;
  logic        pronto;
  logic        erro;
  logic [3:0]  db_estado;

  always #5 clock = ~clock;

  recepcao_serial_bcd #(.CICLOS_BIT(C)) dut (
    .clock         (clock),
    .reset         (reset),
    .entrada_serial(entrada_serial),
    .dados         (dados),
    .pronto        (pronto),
    .erro          (erro),
    .db_estado     (db_estado)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: counts pulses and enforces the pulse/dados invariants.
  int          n_pronto = 0;
  int          n_erro = 0;
  int          ciclo = 0;
  int          ciclo_pronto = 0;
  int          ciclo_parada = 0;
  logic        prev_pronto = 1'b0;
  logic        prev_erro = 1'b0;
  logic        prev_reset = 1'b0;
  logic [11:0] prev_dados = '0;

  always @(negedge clock) begin
    ciclo++;
    if (pronto === 1'b1) begin
      n_pronto++;
      ciclo_pronto = ciclo;
      check("pronto_um_ciclo", prev_pronto, 0);
    end
    if (erro === 1'b1) begin
      n_erro++;
      check("erro_um_ciclo", prev_erro, 0);
    end
    if (pronto === 1'b1 || erro === 1'b1) check("pronto_erro_exclusivos", pronto & erro, 0);
    if (reset && prev_reset && dados !== prev_dados) check("dados_so_com_pronto", pronto, 1);
    prev_pronto = pronto;
    prev_erro   = erro;
    prev_reset  = reset;
    prev_dados  = dados;
  end

  // Reference model: list of digits collected so far in the current packet.
  int          nd = 0;
  logic [3:0]  digs [3];
  logic [11:0] exp_dados = '0;
  int          exp_pronto = 0;
  int          exp_erro = 0;

  task automatic modelo(input logic [6:0] c, input bit ruim);
    if (ruim) begin
      exp_erro++;
      nd = 0;
    end else if (c >= 7'h30 && c <= 7'h39) begin
      if (nd < 3) begin
        digs[nd] = c[3:0];
        nd++;
      end else begin
        exp_erro++;
        nd = 0;
      end
    end else if (c == 7'h23) begin
      if (nd == 3) begin
        exp_dados = {digs[0], digs[1], digs[2]};
        exp_pronto++;
      end else begin
        exp_erro++;
      end
      nd = 0;
    end else begin
      exp_erro++;
      nd = 0;
    end
  endtask

  task automatic confere(input string tag);
    check({tag, "_pronto"}, n_pronto, exp_pronto);
    check({tag, "_erro"}, n_erro, exp_erro);
    check({tag, "_dados"}, dados, exp_dados);
    check({tag, "_estado"}, db_estado, nd);
  endtask

  // Drives one 7O1 frame; returns right after a posedge at the end of the stop bit.
  task automatic envia(input logic [6:0] c, input bit inverte_par, input bit parada);
    logic [9:0] quadro;
    quadro = {parada, (~^c) ^ inverte_par, c, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (i == 9) ciclo_parada = ciclo;
      entrada_serial = quadro[i];
      repeat (C) @(posedge clock);
    end
  endtask

  task automatic envia_char(input logic [6:0] c, input bit inverte_par, input string tag);
    int antes;
    antes = exp_pronto;
    envia(c, inverte_par, 1'b1);
    modelo(c, inverte_par);
    confere(tag);
    if (exp_pronto != antes) begin
      check({tag, "_latencia"},
            (ciclo_pronto - ciclo_parada >= HALF) && (ciclo_pronto - ciclo_parada <= HALF + 8), 1);
    end
  endtask

  task automatic envia_str(input string s, input string tag);
    byte b;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      envia_char(b[6:0], 1'b0, tag);
    end
  endtask

  task automatic idle(input int n);
    entrada_serial = 1'b1;
    repeat (n) @(posedge clock);
  endtask

  task automatic modelo_reset();
    nd = 0;
    exp_dados = '0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] c;
    int         t;
    reset = 1'b0;
    entrada_serial = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_dados", dados, 12'h000);
    check("reset_pronto", pronto, 0);
    check("reset_erro", erro, 0);
    check("reset_estado", db_estado, 0);
    @(posedge clock);
    reset = 1'b1;
    idle(2 * C);

    envia_str("375#", "pac_375");
    check("dados_375", dados, 12'h375);
    check("sem_erro_375", n_erro, 0);

    envia_str("12#", "pac_12_curto");
    check("dados_mantido", dados, 12'h375);
    envia_str("409#", "pac_409");
    check("dados_409", dados, 12'h409);

    envia_char(7'h38, 1'b1, "paridade_ruim");
    envia_str("888#", "pac_888");
    check("dados_888", dados, 12'h888);

    envia(7'h32, 1'b0, 1'b0);
    modelo(7'h32, 1'b1);
    entrada_serial = 1'b0;
    repeat (3 * C) @(posedge clock);
    idle(C);
    confere("enquadramento");
    envia_str("610#", "pac_610");
    check("dados_610", dados, 12'h610);

    entrada_serial = 1'b0;
    repeat (C / 4) @(posedge clock);
    idle(2 * C);
    confere("glitch");
    envia_str("001#", "pac_001");
    check("dados_001", dados, 12'h001);

    envia_str("55", "pre_reset");
    reset = 1'b0;
    #1;
    check("reset_assinc_dados", dados, 12'h000);
    check("reset_assinc_estado", db_estado, 0);
    modelo_reset();
    repeat (4) @(posedge clock);
    reset = 1'b1;
    idle(C);
    envia_str("7#", "pos_reset");
    check("dados_pos_reset", dados, 12'h000);

    // Reset in the middle of a frame leaves nothing behind.
    envia_str("98", "antes_corte");
    entrada_serial = 1'b0;
    repeat (4 * C) @(posedge clock);
    reset = 1'b0;
    entrada_serial = 1'b1;
    modelo_reset();
    repeat (4) @(posedge clock);
    reset = 1'b1;
    idle(3 * C);
    confere("corte_meio_quadro");

    // Line already low at release counts as a start bit.
    reset = 1'b0;
    entrada_serial = 1'b0;
    repeat (4) @(posedge clock);
    reset = 1'b1;
    envia_str("123#", "linha_baixa");
    check("dados_123", dados, 12'h123);

    for (int p = 0; p < 12; p++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 3; k++) envia_char(7'h30 + 7'($urandom_range(0, 9)), 1'b0, "aleat_digito");
        envia_char(7'h23, 1'b0, "aleat_hash");
      end else begin
        for (int k = 0; k < 4; k++) begin
          t = $urandom_range(0, 9);
          if (t < 5) begin
            envia_char(7'h30 + 7'($urandom_range(0, 9)), 1'b0, "aleat_lixo_digito");
          end else if (t < 7) begin
            envia_char(7'h23, 1'b0, "aleat_lixo_hash");
          end else if (t < 9) begin
            do c = 7'($urandom_range(0, 127));
            while ((c >= 7'h30 && c <= 7'h39) || c == 7'h23);
            envia_char(c, 1'b0, "aleat_outro");
          end else begin
            envia_char(7'h30 + 7'($urandom_range(0, 9)), 1'b1, "aleat_paridade");
          end
        end
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2 * C));
    end

    idle(C);
    confere("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/recepcao_serial_bcd.md
RECEPCAO_SERIAL_BCD -- requirements
Module: recepcao_serial_bcd

Interface
REQ-001 Parameter: CICLOS_BIT, default 434, clock cycles per serial bit (50 MHz / 115200 baud); even value >= 4.
REQ-002 Port: clock  input  1  system clock, all logic on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 Port: entrada_serial  input  1  serial line, idle high, frame 7O1.
REQ-005 Port: dados  output  12  last valid measurement, 3 BCD digits, [11:8] most significant.
REQ-006 Port: pronto  output  1  one-cycle pulse when dados is updated.
REQ-007 Port: erro  output  1  one-cycle pulse when a packet is discarded.
REQ-008 Port: db_estado  output  4  debug code of the assembler state.

Function
REQ-009 Input SHALL pass through a 2-flop synchronizer before any use.
REQ-010 Frame: start bit (0), 7 data bits LSB first, odd parity bit, stop bit (1).
REQ-011 Bit FSM states: OCIOSO, INICIO, DADOS, PARIDADE, PARADA.
REQ-012 OCIOSO -> INICIO on synchronized line = 0.
REQ-013 INICIO: re-sample after CICLOS_BIT/2 cycles; 0 -> DADOS, 1 -> OCIOSO with no error (glitch reject).
REQ-014 Each later bit sampled exactly CICLOS_BIT cycles after the previous sample (mid-bit).
REQ-015 Parity error when the 7 data bits plus parity bit contain an even number of ones.
REQ-016 Framing error when the stop bit samples 0; FSM then waits for line = 1 before returning to OCIOSO.
REQ-017 A received character (7 bits + error flags) is presented to the assembler 1 cycle after the stop sample.
REQ-018 Assembler states: ESPERA_D2, ESPERA_D1, ESPERA_D0, ESPERA_HASH (db_estado 0,1,2,3).
REQ-019 Digit = 0x30..0x39; its low nibble is stored in the slot for the current state: D2 -> [11:8], D1 -> [7:4], D0 -> [3:0].
REQ-020 Digit in ESPERA_D2/D1/D0: store and advance one state.
REQ-021 0x23 ('#') in ESPERA_HASH: copy the 3 stored nibbles to dados, pulse pronto, -> ESPERA_D2.
REQ-022 '#' in any other state: pulse erro, discard the partial packet, -> ESPERA_D2 ('#' is the resync marker).
REQ-023 Digit in ESPERA_HASH, any other code, parity error or framing error: pulse erro, discard the partial packet, -> ESPERA_D2.
REQ-024 dados SHALL change only together with pronto; a partial or discarded packet never alters dados.
REQ-025 pronto and erro are mutually exclusive and last exactly 1 cycle.
REQ-026 Latency: pronto asserts 1 cycle after the character presentation for the stop bit of '#' (2 cycles after its stop sample).
REQ-027 Back-to-back frames (next start bit immediately after stop bit) SHALL be received without loss.
REQ-028 There is no line timeout: a packet left incomplete waits indefinitely.

Reset
REQ-029 reset = 0 immediately forces: bit FSM OCIOSO, assembler ESPERA_D2, dados = 12'h000, pronto = 0, erro = 0, db_estado = 0, counters and shift register cleared.
REQ-030 Reset mid-frame or mid-packet discards all partial data, with no pronto and no erro after release.
REQ-031 After release, a frame is accepted only from a fresh falling edge; a line already low at release is treated as a start bit.

Verification
REQ-032 Send "3","7","5","#" with correct parity -> dados = 12'h375, single pronto pulse, erro never asserted.
REQ-033 Send "1","2","#" -> erro pulse on '#', dados unchanged; then send "4","0","9","#" -> dados = 12'h409, pronto.
REQ-034 Send "8" with its parity bit flipped -> erro pulse; then send "8","8","8","#" -> dados = 12'h888.
REQ-035 Send "2" with stop bit 0, hold line low 3 bit times, then send "6","1","0","#" -> one erro pulse, then dados = 12'h610.
REQ-036 Drive a 0 pulse of CICLOS_BIT/4 cycles on an idle line -> no character, no erro; the following valid packet "0","0","1","#" -> dados = 12'h001.
REQ-037 Assert reset after "5","5" are received, release it, then send "7","#" -> erro on '#' (the packet starts at D2), dados = 12'h000.
